word_packer: RTL and testbench
==============================

# word_packer

Parametrised narrow-to-wide beat packer. It collects RATIO input beats of IN_W bits into one OUT_W = IN_W*RATIO word. Flow control is valid/ready on both sides, lane order is selectable per word, and a partial word is flushed on in_last with a lane-keep mask. It sits between byte-oriented front-end sources and word-wide datapaths, replacing the fixed 8→32 free-running packer that had no flow control and no strobe.

## Interface
Parameters:
- IN_W, 8, input beat width in bits (≥1)
- RATIO, 4, beats per output word (≥2); OUT_W = IN_W*RATIO

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  IN_W  input beat
- in_last  in  1  final beat of a burst; closes the word
- msb_first  in  1  lane order for the word; 1 = first beat in the top lane
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts the word
- out_data  out  OUT_W  packed word
- out_keep  out  RATIO  bit i = lane out_data[i*IN_W +: IN_W] holds a real beat
- out_par  out  RATIO  even parity per lane (only with WORD_PACKER_PAR_EN)

## Operation
- Lane counter cnt runs 0..RATIO-1, width $clog2(RATIO). Accumulator acc is OUT_W bits; keep accumulator kacc is RATIO bits.
- Lane placement for beat k:
  - msb_first=1: lane RATIO-1-k
  - msb_first=0: lane k
- msb_first is sampled on the accepted beat with cnt==0 and latched as mode_q for the whole word. Changes mid-word are ignored.
- Accepted beat, not closing: write in_data into the placed lane of acc, set the kacc bit, increment cnt.
- Closing beat (cnt==RATIO-1 or in_last):
  - Load out_data/out_keep with acc/kacc merged with the current beat.
  - Set out_valid.
  - Clear acc, kacc and cnt to 0.
- Unfilled lanes in out_data are 0, and their out_keep bits are 0.
- in_ready = !out_valid || out_ready. A single output register is used, with no extra skid.
- Output handshake: out_valid && out_ready clears out_valid, unless a closing beat is accepted in the same cycle. In that case the new word loads and out_valid stays 1.
- While out_valid && !out_ready: out_data, out_keep and out_par hold stable, and in_ready=0.
- in_last on the beat with cnt==0 produces a single-lane word.
- in_valid with in_ready=0: no state change. The source must hold data.

## Timing
- Reset (rst_n=0 at a clk edge): cnt=0, acc=0, kacc=0, mode_q=0, out_valid=0, out_data=0, out_keep=0, out_par=0. A partial word in progress is discarded.
- Latency: out_valid rises the cycle after the closing beat is accepted.
- Throughput: one beat per clock with out_ready held high. A full word every RATIO cycles with no bubbles.
- in_ready is combinational from out_valid/out_ready only. It has no path from in_valid.

## Configuration
- Macro: WORD_PACKER_PAR_EN.
  - Defined: out_par is present and registered with out_data. out_par[i] = ^out_data[i*IN_W +: IN_W]. Unkept lanes give 0.
  - Undefined: the out_par port and its logic are absent. All other behaviour is identical.

## Structure
- Package word_packer_pkg holds:
  - function lane_idx(k, msb_first, RATIO)
  - localparam helper CNT_W = $clog2(RATIO)
  - the msb/lsb order encoding constants
- One sub-module is natural: word_packer_oreg. It holds the output register, out_valid, the in_ready generation and the optional parity. The top level keeps the counter and accumulator.

## Test plan
- IN_W=8, RATIO=4, msb_first=1, out_ready=1, beats 11,22,33,44 back-to-back → next cycle out_data=0x11223344, out_keep=4'b1111. in_ready is constantly 1.
- Same beats with msb_first=0 → out_data=0x44332211, out_keep=4'b1111. Toggling msb_first on beats 2–4 has no effect.
- msb_first=1, beats AA, BB with in_last on BB → out_data=0xAABB0000, out_keep=4'b1100. The following beats start at cnt=0. Same with msb_first=0 → 0x0000BBAA, 4'b0011.
- out_ready=0 after a word completes → in_ready=0 and outputs held for 5 cycles. Raising out_ready while a closing beat arrives in the same cycle → the new word is loaded back-to-back and no beat is lost.
- rst_n=0 for one clk after 2 of 4 beats → all outputs 0 the next cycle. Beats 01,02,03,04 then yield 0x01020304 with no stale lanes.
- WORD_PACKER_PAR_EN defined, beats 01,03,07,FF → out_par=4'b1010 (lane3=01, lane2=03, lane1=07, lane0=FF).

Source files
------------

// File: rtl/word_packer_pkg.sv
// Shared types and helpers for the word_packer narrow-to-wide beat packer.
package word_packer_pkg;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } lane_order_e;

  // Width of the lane counter for a given beats-per-word ratio.
  function automatic int cnt_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Output lane that beat k of a word lands in.
  function automatic int lane_idx(input int k, input logic msb_first, input int ratio);
    return (msb_first == MSB_FIRST) ? (ratio - 1 - k) : k;
  endfunction

endpackage

// File: rtl/word_packer_oreg.sv
// Output register stage: holds the packed word, keep mask and valid flag, and
// generates in_ready. Optional per-lane parity under WORD_PACKER_PAR_EN.
module word_packer_oreg
  import word_packer_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int RATIO = 4,
  parameter int OUT_W = IN_W * RATIO
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [OUT_W-1:0] load_data,
  input  logic [RATIO-1:0] load_keep,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic [RATIO-1:0] out_keep
`ifdef WORD_PACKER_PAR_EN
  ,
  output logic [RATIO-1:0] out_par
`endif
);

  // Single output register with no skid: accept only if the slot is free or draining now.
  assign in_ready = !out_valid || out_ready;

`ifdef WORD_PACKER_PAR_EN
  logic [RATIO-1:0] par_next;

  // NOTE: every always_comb output gets a default before any conditional logic, so no latch is inferred.
  always_comb begin
    par_next = '0;
    for (int i = 0; i < RATIO; i++) begin
      par_next[i] = ^load_data[i*IN_W +: IN_W];
    end
  end
`endif

  // NOTE: reset is synchronous, so it is tested inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
`ifdef WORD_PACKER_PAR_EN
      out_par   <= '0;
`endif
    end else if (load) begin
      // A closing beat wins over a simultaneous drain, keeping words back-to-back.
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_keep  <= load_keep;
`ifdef WORD_PACKER_PAR_EN
      out_par   <= par_next;
`else
      // Without parity only the word and its keep mask are registered.
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/word_packer.sv
// Narrow-to-wide beat packer with valid/ready flow control, per-word lane order
// and keep mask. Define WORD_PACKER_PAR_EN to add registered per-lane even parity.
module word_packer
  import word_packer_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int RATIO = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_last,
  input  logic                  msb_first,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IN_W*RATIO-1:0] out_data,
  output logic [RATIO-1:0]      out_keep
`ifdef WORD_PACKER_PAR_EN
  ,
  output logic [RATIO-1:0]      out_par
`endif
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int CNT_W = cnt_w(RATIO);

  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] acc;
  logic [RATIO-1:0] kacc;
  logic             mode_q;

  logic             accept;
  logic             closing;
  logic             cur_mode;
  logic [CNT_W-1:0] lane;
  logic [OUT_W-1:0] merged;
  logic [RATIO-1:0] kmerged;

  assign accept   = in_valid && in_ready;
  assign closing  = accept && ((cnt == CNT_W'(RATIO - 1)) || in_last);
  // The first beat of a word decides its lane order; later beats follow mode_q.
  assign cur_mode = (cnt == '0) ? msb_first : mode_q;
  assign lane     = CNT_W'(lane_idx(int'(cnt), cur_mode, RATIO));

  always_comb begin
    merged  = acc;
    kmerged = kacc;
    for (int i = 0; i < RATIO; i++) begin
      if (lane == CNT_W'(i)) begin
        merged[i*IN_W +: IN_W] = in_data;
        kmerged[i]             = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      kacc   <= '0;
      mode_q <= LSB_FIRST;
    end else if (accept) begin
      if (cnt == '0) mode_q <= msb_first;
      if (closing) begin
        cnt  <= '0;
        acc  <= '0;
        kacc <= '0;
      end else begin
        cnt  <= cnt + 1'b1;
        acc  <= merged;
        kacc <= kmerged;
      end
    end
  end

  word_packer_oreg #(
    .IN_W  (IN_W),
    .RATIO (RATIO),
    .OUT_W (OUT_W)
  ) u_oreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (closing),
    .load_data (merged),
    .load_keep (kmerged),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_keep  (out_keep)
`ifdef WORD_PACKER_PAR_EN
    ,
    .out_par   (out_par)
`endif
  );

endmodule

// File: tb/tb_word_packer.sv
// Self-checking bench for word_packer: directed steps from the test plan followed
// by randomized traffic, compared against a queue-based reference model.
module tb_word_packer;

  localparam int IN_W  = 8;
  localparam int RATIO = 4;
  localparam int OUT_W = IN_W * RATIO;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_last = 1'b0;
  logic             msb_first = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic [RATIO-1:0] out_keep;
`ifdef WORD_PACKER_PAR_EN
  logic [RATIO-1:0] out_par;
`endif

  word_packer #(.IN_W(IN_W), .RATIO(RATIO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .msb_first (msb_first),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep)
`ifdef WORD_PACKER_PAR_EN
    ,
    .out_par   (out_par)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: beats of the word in progress, its lane order, and the output slot.
  logic [IN_W-1:0]  mq[$];
  logic             m_mode = 1'b0;
  logic             m_valid = 1'b0;
  logic [OUT_W-1:0] m_data = '0;
  logic [RATIO-1:0] m_keep = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RATIO-1:0] model_par(input logic [OUT_W-1:0] w);
    logic [RATIO-1:0] p;
    logic [IN_W-1:0]  b;
    p = '0;
    for (int i = 0; i < RATIO; i++) begin
      b = IN_W'(w >> (i * IN_W));
      p[i] = ($countones(b) % 2) == 1;
    end
    return p;
  endfunction

  // One clock: check in_ready, advance the model with the current inputs, then check outputs.
  task automatic tick();
    logic exp_rdy;
    logic closed;
    int   lane;
    #1;
    exp_rdy = !m_valid || out_ready;
    check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    closed = 1'b0;
    if (!rst_n) begin
      mq.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_keep  = '0;
    end else begin
      if (in_valid && exp_rdy) begin
        if (mq.size() == 0) m_mode = msb_first;
        mq.push_back(in_data);
        if (mq.size() == RATIO || in_last) begin
          m_data = '0;
          m_keep = '0;
          foreach (mq[k]) begin
            lane   = m_mode ? (RATIO - 1 - k) : k;
            m_data = m_data | (OUT_W'(mq[k]) << (lane * IN_W));
            m_keep = m_keep | (RATIO'(1) << lane);
          end
          mq.delete();
          m_valid = 1'b1;
          closed  = 1'b1;
        end
      end
      if (!closed && m_valid && out_ready) m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    check("out_data", 64'(out_data), 64'(m_data));
    check("out_keep", 64'(out_keep), 64'(m_keep));
`ifdef WORD_PACKER_PAR_EN
    check("out_par", 64'(out_par), 64'(model_par(m_data)));
`endif
  endtask

  task automatic beat(input logic [IN_W-1:0] d, input logic last, input logic mode);
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = last;
    msb_first = mode;
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset and reset-state values.
    rst_n = 1'b0;
    idle(2);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Full word, msb-first, back-to-back.
    beat(8'h11, 1'b0, 1'b1);
    beat(8'h22, 1'b0, 1'b1);
    beat(8'h33, 1'b0, 1'b1);
    beat(8'h44, 1'b0, 1'b1);
    check("msb_word", 64'(out_data), 64'h11223344);
    check("msb_keep", 64'(out_keep), 64'hF);

    // Lsb-first, with msb_first toggled mid-word (must be ignored).
    beat(8'h11, 1'b0, 1'b0);
    beat(8'h22, 1'b0, 1'b1);
    beat(8'h33, 1'b0, 1'b1);
    beat(8'h44, 1'b0, 1'b1);
    check("lsb_word", 64'(out_data), 64'h44332211);
    check("lsb_keep", 64'(out_keep), 64'hF);

    // Partial words flushed by in_last.
    beat(8'hAA, 1'b0, 1'b1);
    beat(8'hBB, 1'b1, 1'b1);
    check("part_msb_word", 64'(out_data), 64'hAABB0000);
    check("part_msb_keep", 64'(out_keep), 64'hC);
    beat(8'hAA, 1'b0, 1'b0);
    beat(8'hBB, 1'b1, 1'b0);
    check("part_lsb_word", 64'(out_data), 64'h0000BBAA);
    check("part_lsb_keep", 64'(out_keep), 64'h3);
    beat(8'h5A, 1'b1, 1'b0);
    check("single_keep", 64'(out_keep), 64'h1);
    idle(2);

    // Backpressure: stall with a waiting beat, then drain and load in the same cycle.
    out_ready = 1'b0;
    beat(8'h01, 1'b0, 1'b1);
    beat(8'h02, 1'b0, 1'b1);
    beat(8'h03, 1'b0, 1'b1);
    beat(8'h04, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) beat(8'h05, 1'b1, 1'b1);
    check("stall_ready", {63'd0, in_ready}, 64'd0);
    check("stall_hold", 64'(out_data), 64'h01020304);
    out_ready = 1'b1;
    beat(8'h05, 1'b1, 1'b1);
    check("b2b_valid", {63'd0, out_valid}, 64'd1);
    check("b2b_word", 64'(out_data), 64'h05000000);
    idle(2);

    // Reset in the middle of a word discards the partial lanes.
    beat(8'hE1, 1'b0, 1'b1);
    beat(8'hE2, 1'b0, 1'b1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("mid_rst_data", 64'(out_data), 64'd0);
    check("mid_rst_keep", 64'(out_keep), 64'd0);
    rst_n = 1'b1;
    beat(8'h01, 1'b0, 1'b1);
    beat(8'h03, 1'b0, 1'b1);
    beat(8'h07, 1'b0, 1'b1);
    beat(8'hFF, 1'b0, 1'b1);
    check("post_rst_word", 64'(out_data), 64'h010307FF);
`ifdef WORD_PACKER_PAR_EN
    check("par_vector", 64'(out_par), 64'hA);
`endif
    idle(1);

    // Randomized traffic with random backpressure, bursts and lane order.
    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0) begin
        beat(IN_W'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom));
      end else begin
        idle(1);
      end
    end
    out_ready = 1'b1;
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
